// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared types and helpers for the traffic phase sequencer: phase codes, lamp patterns,
// 2-digit BCD durations and the fixed phase order.
package traffic_phase_ctrl_pkg;

  typedef enum logic [2:0] {
    PhInit  = 3'd0,
    PhNsG   = 3'd1,
    PhNsY   = 3'd2,
    PhAr1   = 3'd3,
    PhEwG   = 3'd4,
    PhEwY   = 3'd5,
    PhAr2   = 3'd6,
    PhFlash = 3'd7
  } phase_t;

  // {ten, unit}
  typedef logic [7:0] bcd2_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam bcd2_t DEF_DUR_NS_G = 8'h25;
  localparam bcd2_t DEF_DUR_EW_G = 8'h20;
  localparam bcd2_t DEF_DUR_Y    = 8'h03;
  localparam bcd2_t DEF_DUR_AR   = 8'h02;

  function automatic logic bcd2_ok(bcd2_t v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // A zero load would never reach the done value, so it is treated as one tick.
  function automatic bcd2_t bcd2_clamp(bcd2_t v);
    return (v == 8'h00) ? 8'h01 : v;
  endfunction

  function automatic phase_t phase_next(phase_t p);
    phase_t n;
    case (p)
      PhInit:  n = PhNsG;
      PhNsG:   n = PhNsY;
      PhNsY:   n = PhAr1;
      PhAr1:   n = PhEwG;
      PhEwG:   n = PhEwY;
      PhEwY:   n = PhAr2;
      PhAr2:   n = PhNsG;
      default: n = PhInit;
    endcase
    return n;
  endfunction

  // Returns {ns_lamp, ew_lamp}; at most one road is ever non-red.
  function automatic logic [5:0] phase_lamps(phase_t p);
    logic [5:0] l;
    case (p)
      PhNsG:   l = {LAMP_GRN, LAMP_RED};
      PhNsY:   l = {LAMP_YEL, LAMP_RED};
      PhEwG:   l = {LAMP_RED, LAMP_GRN};
      PhEwY:   l = {LAMP_RED, LAMP_YEL};
      default: l = {LAMP_RED, LAMP_RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Signal bundle between the phase sequencer and its time base, countdown stage and lamp drivers.
interface traffic_phase_ctrl_if;
  logic       tick;
  logic       run;
  logic       cnt_done;
  logic       night;
  logic       cnt_en;
  logic       cnt_rst_n;
  logic [3:0] val_ten;
  logic [3:0] val_unit;
  logic [2:0] ns_lamp;
  logic [2:0] ew_lamp;
  logic [2:0] phase;

  modport master (
    input  tick, run, cnt_done, night,
    output cnt_en, cnt_rst_n, val_ten, val_unit, ns_lamp, ew_lamp, phase
  );

  modport slave (
    output tick, run, cnt_done, night,
    input  cnt_en, cnt_rst_n, val_ten, val_unit, ns_lamp, ew_lamp, phase
  );
endinterface

// File: rtl/traffic_phase_ctrl_phase_dur_lut.sv
// Load value for the countdown: duration of the phase entered at the next advance,
// with a zero duration clamped to one tick.
module phase_dur_lut
  import traffic_phase_ctrl_pkg::*;
#(
  parameter bcd2_t DUR_NS_G = DEF_DUR_NS_G,
  parameter bcd2_t DUR_EW_G = DEF_DUR_EW_G,
  parameter bcd2_t DUR_Y    = DEF_DUR_Y,
  parameter bcd2_t DUR_AR   = DEF_DUR_AR
) (
  input  phase_t phase,
  output bcd2_t  dur
);

  always_comb begin
    dur = bcd2_clamp(DUR_NS_G);
    case (phase)
      PhNsG, PhEwG: dur = bcd2_clamp(DUR_Y);
      PhNsY, PhEwY: dur = bcd2_clamp(DUR_AR);
      PhAr1:        dur = bcd2_clamp(DUR_EW_G);
      default:      dur = bcd2_clamp(DUR_NS_G);
    endcase
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road phase sequencer driving lamps and the downstream BCD countdown.
// Define NIGHT_FLASH_EN to enable the night flashing-yellow mode.
module traffic_phase_ctrl
  import traffic_phase_ctrl_pkg::*;
#(
  parameter bcd2_t DUR_NS_G = DEF_DUR_NS_G,
  parameter bcd2_t DUR_EW_G = DEF_DUR_EW_G,
  parameter bcd2_t DUR_Y    = DEF_DUR_Y,
  parameter bcd2_t DUR_AR   = DEF_DUR_AR
) (
  input logic                 clk,
  input logic                 reset_n,
  traffic_phase_ctrl_if.master bus
);

  if (!(bcd2_ok(DUR_NS_G) && bcd2_ok(DUR_EW_G) && bcd2_ok(DUR_Y) && bcd2_ok(DUR_AR)))
  begin : g_dur_bad
    $error("traffic_phase_ctrl: duration parameter has a BCD digit above 9");
  end

  phase_t     state_q, state_d;
  logic [2:0] ns_q, ns_d;
  logic [2:0] ew_q, ew_d;
  logic       rst_q, rst_d;
  logic       adv;
  bcd2_t      dur;

`ifdef NIGHT_FLASH_EN
  logic yel_q, yel_d;
`else
  logic unused_night;
  assign unused_night = bus.night;
`endif

  phase_dur_lut #(
    .DUR_NS_G (DUR_NS_G),
    .DUR_EW_G (DUR_EW_G),
    .DUR_Y    (DUR_Y),
    .DUR_AR   (DUR_AR)
  ) u_lut (
    .phase (state_q),
    .dur   (dur)
  );

  assign bus.cnt_en = bus.tick & bus.run & (state_q != PhFlash);
  // INIT leaves on the first enabled tick: the counter is blank and loads on this same edge.
  assign adv = bus.cnt_en & ((state_q == PhInit) | bus.cnt_done);

  always_comb begin
    state_d = state_q;
    rst_d   = 1'b1;
`ifdef NIGHT_FLASH_EN
    yel_d   = yel_q;
`endif
    if (adv) begin
      state_d = phase_next(state_q);
    end
`ifdef NIGHT_FLASH_EN
    if (bus.tick && bus.night) begin
      state_d = PhFlash;
      yel_d   = (state_q == PhFlash) ? ~yel_q : 1'b1;
    end else if (bus.tick && (state_q == PhFlash)) begin
      state_d = PhInit;
      rst_d   = 1'b0;
    end
`endif
    {ns_d, ew_d} = phase_lamps(state_d);
`ifdef NIGHT_FLASH_EN
    if (state_d == PhFlash) begin
      ns_d = yel_d ? LAMP_YEL : LAMP_OFF;
      ew_d = yel_d ? LAMP_YEL : LAMP_OFF;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PhInit;
      ns_q    <= LAMP_RED;
      ew_q    <= LAMP_RED;
      rst_q   <= 1'b0;
`ifdef NIGHT_FLASH_EN
      yel_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      rst_q   <= rst_d;
`ifdef NIGHT_FLASH_EN
      yel_q   <= yel_d;
`endif
    end
  end

  assign bus.cnt_rst_n = rst_q;
  assign bus.ns_lamp   = ns_q;
  assign bus.ew_lamp   = ew_q;
  assign bus.phase     = state_q;
  assign bus.val_ten   = dur[7:4];
  assign bus.val_unit  = dur[3:0];

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench: default-duration DUT and a DUR_AR=00 DUT share tick/run/reset, each
// fed by a behavioural countdown.
module tb_traffic_phase_ctrl;

  localparam logic [2:0] INIT  = 3'd0;
  localparam logic [2:0] NSG   = 3'd1;
  localparam logic [2:0] NSY   = 3'd2;
  localparam logic [2:0] AR1   = 3'd3;
  localparam logic [2:0] EWG   = 3'd4;
  localparam logic [2:0] EWY   = 3'd5;
  localparam logic [2:0] AR2   = 3'd6;
  localparam logic [2:0] FLASH = 3'd7;

  typedef struct packed {
    logic [2:0] ph0, ns0, ew0, ph1, ns1, ew1;
    logic [7:0] v0, v1;
    logic       en0, en1, rst0, rst1;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n, tick, run, night;
  int   cnt0, cnt1;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  logic [2:0] mph [2];
  int         mrem[2];
  logic       myel[2];
  logic       mrst[2];

  always #5 clk = ~clk;

  traffic_phase_ctrl_if bus0();
  traffic_phase_ctrl_if bus1();

  assign bus0.tick = tick;
  assign bus0.run = run;
  assign bus0.night = night;
  assign bus1.tick = tick;
  assign bus1.run = run;
  assign bus1.night = night;
  assign bus0.cnt_done = (cnt0 == 1);
  assign bus1.cnt_done = (cnt1 == 1);

  traffic_phase_ctrl u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  traffic_phase_ctrl #(
    .DUR_AR (8'h00)
  ) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  function automatic int bcd2int(logic [3:0] t, logic [3:0] u);
    return int'(t) * 10 + int'(u);
  endfunction

  // Countdown stage: loads when blank or done, else decrements; done while count == 1.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt0 <= 0;
      cnt1 <= 0;
    end else begin
      if (!bus0.cnt_rst_n) cnt0 <= 0;
      else if (bus0.cnt_en) cnt0 <= (cnt0 <= 1) ? bcd2int(bus0.val_ten, bus0.val_unit) : cnt0 - 1;
      if (!bus1.cnt_rst_n) cnt1 <= 0;
      else if (bus1.cnt_en) cnt1 <= (cnt1 <= 1) ? bcd2int(bus1.val_ten, bus1.val_unit) : cnt1 - 1;
    end
  end

  function automatic int dur_t(int i, logic [2:0] p);
    case (p)
      NSG:      return 25;
      NSY, EWY: return 3;
      AR1, AR2: return (i == 0) ? 2 : 1;
      EWG:      return 20;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [7:0] exp_val(int i, logic [2:0] p);
    case (p)
      NSG, EWG: return 8'h03;
      NSY, EWY: return (i == 0) ? 8'h02 : 8'h01;
      AR1:      return 8'h20;
      default:  return 8'h25;
    endcase
  endfunction

  function automatic logic [5:0] exp_lamps(logic [2:0] p, logic y);
    case (p)
      NSG:     return 6'b001_100;
      NSY:     return 6'b010_100;
      EWG:     return 6'b100_001;
      EWY:     return 6'b100_010;
      FLASH:   return y ? 6'b010_010 : 6'b000_000;
      default: return 6'b100_100;
    endcase
  endfunction

  function automatic logic [2:0] nxt(logic [2:0] p);
    case (p)
      NSG:     return NSY;
      NSY:     return AR1;
      AR1:     return EWG;
      EWG:     return EWY;
      EWY:     return AR2;
      default: return NSG;
    endcase
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      mrst[i] = 1'b1;
`ifdef NIGHT_FLASH_EN
      if (night) begin
        if (mph[i] == FLASH) myel[i] = ~myel[i];
        else begin
          mph[i]  = FLASH;
          myel[i] = 1'b1;
        end
      end else if (mph[i] == FLASH) begin
        mph[i]  = INIT;
        mrst[i] = 1'b0;
      end else
`endif
      if (run) begin
        if (mph[i] == INIT) begin
          mph[i]  = NSG;
          mrem[i] = 25;
        end else if (mrem[i] == 1) begin
          mph[i]  = nxt(mph[i]);
          mrem[i] = dur_t(i, mph[i]);
        end else begin
          mrem[i] = mrem[i] - 1;
        end
      end
    end
  endtask

  task automatic chk(string nm, logic [7:0] got, logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic do_tick();
    exp_t e;
    logic [5:0] l0, l1;
    e.en0 = run && (mph[0] != FLASH);
    e.en1 = run && (mph[1] != FLASH);
    model_step();
    l0 = exp_lamps(mph[0], myel[0]);
    l1 = exp_lamps(mph[1], myel[1]);
    e.ph0 = mph[0];
    e.ns0 = l0[5:3];
    e.ew0 = l0[2:0];
    e.v0 = exp_val(0, mph[0]);
    e.rst0 = mrst[0];
    e.ph1 = mph[1];
    e.ns1 = l1[5:3];
    e.ew1 = l1[2:0];
    e.v1 = exp_val(1, mph[1]);
    e.rst1 = mrst[1];
    q.push_back(e);
    @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  // cnt_en is sampled while tick is high; state and outputs on the next falling edge.
  task automatic monitor();
    exp_t e;
    logic s0, s1;
    logic pend = 1'b0;
    forever begin
      @(negedge clk);
      if (tick) begin
        s0 = bus0.cnt_en;
        s1 = bus1.cnt_en;
        pend = 1'b1;
      end else if (pend) begin
        pend = 1'b0;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard: got empty queue want an entry at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("cnt_en0", 8'(s0), 8'(e.en0));
          chk("phase0", 8'(bus0.phase), 8'(e.ph0));
          chk("ns_lamp0", 8'(bus0.ns_lamp), 8'(e.ns0));
          chk("ew_lamp0", 8'(bus0.ew_lamp), 8'(e.ew0));
          chk("val0", {bus0.val_ten, bus0.val_unit}, e.v0);
          chk("cnt_rst_n0", 8'(bus0.cnt_rst_n), 8'(e.rst0));
          chk("cnt_en1", 8'(s1), 8'(e.en1));
          chk("phase1", 8'(bus1.phase), 8'(e.ph1));
          chk("ns_lamp1", 8'(bus1.ns_lamp), 8'(e.ns1));
          chk("ew_lamp1", 8'(bus1.ew_lamp), 8'(e.ew1));
          chk("val1", {bus1.val_ten, bus1.val_unit}, e.v1);
          chk("cnt_rst_n1", 8'(bus1.cnt_rst_n), 8'(e.rst1));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish want finish before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    tick = 1'b0;
    run = 1'b1;
    night = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mph[i] = INIT;
      mrem[i] = 0;
      myel[i] = 1'b0;
      mrst[i] = 1'b1;
    end
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_phase", 8'(bus0.phase), 8'(INIT));
    chk("rst_ns", 8'(bus0.ns_lamp), 8'h04);
    chk("rst_ew", 8'(bus0.ew_lamp), 8'h04);
    chk("rst_cnt_rst_n", 8'(bus0.cnt_rst_n), 8'h0);
    chk("rst_val", {bus0.val_ten, bus0.val_unit}, 8'h25);
    chk("rst_val1", {bus1.val_ten, bus1.val_unit}, 8'h25);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ns", 8'(bus0.ns_lamp), 8'h04);
    chk("idle_cnt_rst_n", 8'(bus0.cnt_rst_n), 8'h1);

    // INIT -> NS_G, then two full cycles
    repeat (111) do_tick();

    // freeze mid EW_G
    for (int k = 0; k < 60 && mph[0] != EWG; k++) do_tick();
    repeat (5) do_tick();
    run = 1'b0;
    repeat (5) do_tick();
    run = 1'b1;
    repeat (20) do_tick();

    // async reset one tick into NS_Y
    for (int k = 0; k < 80 && mph[0] != NSY; k++) do_tick();
    do_tick();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_ns", 8'(bus0.ns_lamp), 8'h04);
    chk("arst_ew", 8'(bus0.ew_lamp), 8'h04);
    chk("arst_cnt_rst_n", 8'(bus0.cnt_rst_n), 8'h0);
    chk("arst_phase", 8'(bus0.phase), 8'(INIT));
    chk("arst_phase1", 8'(bus1.phase), 8'(INIT));
    for (int i = 0; i < 2; i++) begin
      mph[i] = INIT;
      myel[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (3) do_tick();

`ifdef NIGHT_FLASH_EN
    for (int k = 0; k < 80 && mph[0] != EWG; k++) do_tick();
    do_tick();
    night = 1'b1;
    repeat (3) do_tick();
    night = 1'b0;
    repeat (2) do_tick();
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
